// File: rtl/fir_pkg.sv
// Shared definitions for the parametrised FIR family.
//   clog2       : ceiling log2, used for the tap-address width and accumulator growth
//   acc_width   : accumulator width for a given data width, coefficient width and tap count
//   DefCoef     : value every coefficient takes at reset (+1)
//   sample_t / coef_t : signed sample and coefficient types at the default widths
package fir_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefCoefW = 8;
  localparam int          DefCoef  = 1;

  typedef logic signed [DefDataW-1:0] sample_t;
  typedef logic signed [DefCoefW-1:0] coef_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < n) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Full-precision sum of taps products of data_w x coef_w bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: round-half-up, arithmetic right shift, then limit to OUT_W.
// Build option: FIR_FILTER_SAT_EN defined -> saturate to the signed OUT_W range;
//               undefined -> keep the low OUT_W bits (two's-complement wrap).
// Ports:
//   acc    in  ACC_W  signed accumulator
//   result out OUT_W  signed scaled and limited sample
// Assumes OUT_W <= ACC_W.
module fir_round_sat #(
  parameter int unsigned ACC_W     = 19,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] result
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int unsigned ExtW = ACC_W + 1;

  logic signed [ExtW-1:0] ext;
  logic signed [ExtW-1:0] scaled;

  assign ext = ExtW'(acc);

  if (OUT_SHIFT > 0) begin : g_round
    localparam logic signed [ExtW-1:0] Half = ExtW'(1) << (OUT_SHIFT - 1);
    assign scaled = (ext + Half) >>> OUT_SHIFT;
  end else begin : g_pass
    assign scaled = ext;
  end

`ifdef FIR_FILTER_SAT_EN
  localparam logic signed [ExtW-1:0] Max = {{(ExtW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ExtW-1:0] Min = {{(ExtW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    result = scaled[OUT_W-1:0];
    if (scaled > Max) begin
      result = Max[OUT_W-1:0];
    end else if (scaled < Min) begin
      result = Min[OUT_W-1:0];
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^scaled[ExtW-1:OUT_W];
  assign result    = scaled[OUT_W-1:0];
`endif

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised signed direct-form FIR with runtime-loadable coefficients and
// valid/ready handshakes on both sides.
// Pipeline: acceptance edge registers products of the post-shift history (S1);
// the next edge registers the rounded/scaled/limited sum (S2 = output register).
// Build option: FIR_FILTER_SAT_EN selects output saturation instead of wrap.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_data  sample input handshake
//   out_valid/out_ready/out_data filtered output handshake
//   coef_we/coef_addr/coef_data coefficient write port (addresses >= TAPS ignored)
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned TAPS      = 5,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     coef_we,
  input  logic [clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0] coef_data
);

  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam int unsigned AccW  = acc_width(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic signed [DATA_W-1:0] hist_d [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ProdW-1:0]  prod_q [TAPS];
  logic                     s1_valid_q;
  logic                     out_valid_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic signed [AccW-1:0]   acc;
  logic signed [OUT_W-1:0]  scaled;
  logic                     stall;
  logic                     accept;

  // A full pipeline freezes as a whole while the output is held.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // History as it will look after this edge's shift.
  always_comb begin
    hist_d[0] = in_data;
    for (int k = 1; k < TAPS; k++) begin
      hist_d[k] = hist_q[k-1];
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + AccW'(prod_q[k]);
    end
  end

  fir_round_sat #(
    .ACC_W    (AccW),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .acc   (acc),
    .result(scaled)
  );

  // Delay line and coefficient bank. Writes land even during stall; products
  // formed on the same edge still see the old coefficient.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        hist_q[k] <= '0;
        coef_q[k] <= COEF_W'(DefCoef);
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_q[k] <= hist_d[k];
        end
      end
      if (coef_we && (32'(coef_addr) < TAPS)) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  // S1: products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= '0;
      end
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        for (int k = 0; k < TAPS; k++) begin
          prod_q[k] <= ProdW'(coef_q[k]) * ProdW'(hist_d[k]);
        end
      end
    end
  end

  // S2: output register. Not stalled means the current output (if any) is
  // being taken, so a new S1 result replaces it or out_valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      if (s1_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= scaled;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param at default parameters.
module tb_fir_filter_param;
  import fir_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  sample_t           in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              coef_we;
  logic [2:0]        coef_addr;
  coef_t             coef_data;

  always #5 clk = ~clk;

  fir_filter_param dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data)
  );

  typedef struct {
    logic iv;
    int   din;
    logic we;
    int   addr;
    int   cd;
    logic ev;
    int   ed;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input int din, input logic we, input int addr,
                     input int cd, input logic ev, input int ed);
    vec_t v;
    v.iv = iv; v.din = din; v.we = we; v.addr = addr; v.cd = cd; v.ev = ev; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
  endtask

  // Inputs are driven 1 time unit after an edge; outputs checked 1 after the next.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].iv;
      in_data   = 8'(tbl[i].din);
      coef_we   = tbl[i].we;
      coef_addr = 3'(tbl[i].addr);
      coef_data = 8'(tbl[i].cd);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].out_valid", name, i), int'(out_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("%s[%0d].out_data", name, i), int'(out_data), tbl[i].ed);
      end
    end
    idle();
    tbl.delete();
  endtask

  task automatic do_reset();
    idle();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Impulse through all-ones coefficients: five ones then zeros.
  task automatic add_impulse();
    add(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x[12];
    int c[5];
    int yexp[12];
    int got[$];
    int idx;
    int held;
    int exp3[5];

    rst = 1'b1;
    idle();
    #1;
    rst = 1'b0;
    #1;
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.out_data", int'(out_data), 0);
    check("reset.in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Impulse with default coefficients; out_valid appears on the second edge.
    add_impulse();
    run_table("impulse");

    // Loaded coefficients 1,2,4,2,1 with a step of 10.
    do_reset();
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 1, 2, 0, 0);
    add(0, 0, 1, 2, 4, 0, 0);
    add(0, 0, 1, 3, 2, 0, 0);
    add(0, 0, 1, 4, 1, 0, 0);
    add(1, 10, 0, 0, 0, 0, 0);
    add(1, 10, 0, 0, 0, 1, 10);
    add(1, 10, 0, 0, 0, 1, 30);
    add(1, 10, 0, 0, 0, 1, 70);
    add(1, 10, 0, 0, 0, 1, 90);
    add(1, 10, 0, 0, 0, 1, 100);
    add(1, 10, 0, 0, 0, 1, 100);
    run_table("step");

    // Overflowing step of 100 with default coefficients.
`ifdef FIR_FILTER_SAT_EN
    exp3 = '{100, 127, 127, 127, 127};
`else
    exp3 = '{100, -56, 44, -112, -12};
`endif
    do_reset();
    add(1, 100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 100, 0, 0, 0, 1, exp3[i]);
    run_table("limit");

    // Backpressure: 5 stalled cycles mid-stream must not lose or repeat samples.
    do_reset();
    c = '{1, 2, 4, 2, 1};
    for (int k = 0; k < 5; k++) add(0, 0, 1, k, c[k], 0, 0);
    run_table("stall_cfg");
    for (int n = 0; n < 12; n++) x[n] = n + 1;
    for (int n = 0; n < 12; n++) begin
      yexp[n] = 0;
      for (int k = 0; k < 5; k++) begin
        if (n - k >= 0) yexp[n] += c[k] * x[n-k];
      end
    end
    idx  = 0;
    held = 0;
    for (int cyc = 0; cyc < 80 && got.size() < 12; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (idx < 12);
      if (idx < 12) in_data = 8'(x[idx]);
      else in_data = '0;
      #1;
      if (cyc == 6) held = int'(out_data);
      if (!out_ready) begin
        check($sformatf("stall[%0d].in_ready", cyc), int'(in_ready), 0);
        check($sformatf("stall[%0d].out_valid", cyc), int'(out_valid), 1);
        check($sformatf("stall[%0d].out_data", cyc), int'(out_data), held);
      end
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    idle();
    check("stall.count", got.size(), 12);
    for (int n = 0; n < 12; n++) begin
      check($sformatf("stall.out[%0d]", n), (n < got.size()) ? got[n] : -999, yexp[n]);
    end

    // Asynchronous reset with two samples in flight.
    do_reset();
    add(0, 0, 1, 0, 2, 0, 0);
    add(1, 50, 0, 0, 0, 0, 0);
    add(1, 60, 0, 0, 0, 1, 100);
    run_table("inflight");
    #2;
    rst = 1'b0;
    #1;
    check("async_rst.out_valid", int'(out_valid), 0);
    check("async_rst.out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    add_impulse();
    run_table("impulse_after_rst");

    // Out-of-range coefficient address is ignored.
    do_reset();
    add(0, 0, 1, 7, 50, 0, 0);
    add_impulse();
    run_table("bad_addr");

    // Write coincident with acceptance applies from the next sample.
    do_reset();
    add(1, 1, 1, 0, 5, 0, 0);
    add(1, 2, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 11);
    add(1, 0, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 1, 2);
    add(1, 0, 0, 0, 0, 1, 0);
    run_table("coincident_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
- Parametrised successor to the fixed 5-tap low-pass FIR.
- Generic signed direct-form FIR with configurable data width, coefficient width and tap count.
- Coefficients are runtime-loadable; output uses rounding and scaling.
- Input and output use valid/ready handshakes, so the block sits between sample sources and downstream DSP stages with backpressure.

Parameters:
- DATA_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width.
- TAPS, 5, number of taps (>=2).
- OUT_W, 8, signed output width.
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output (0..ACC_W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  OUT_W  signed filtered sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index to write.
- coef_data  in  COEF_W  signed coefficient value.

Behaviour:
- Reset (one clock; reset is asynchronous and active-low, port rst):
  - Clears the delay line, all pipeline valids, out_valid=0 and out_data=0.
  - Every coefficient resets to +1.
  - Reset mid-operation discards in-flight samples without emitting them.
- Acceptance and delay line:
  - A sample is accepted when in_valid && in_ready.
  - Only on acceptance does the delay line shift: h[0] <= in_data, h[k] <= h[k-1].
- Pipeline:
  - S1 registers the TAPS products coef[k]*h'[k], where h' is the post-shift history including the new sample. Each product is DATA_W+COEF_W bits.
  - S2 sums, rounds, scales and limits into the output register.
- Latency: out_valid rises 2 cycles after the acceptance edge.
- Stall:
  - stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, S1, S2 and the delay line hold and out_data is held stable.
  - No sample is lost or duplicated. At most 2 accepted samples are pending.
- Output handshake: out_valid clears on out_ready unless a new result moves into S2 on the same edge.
- Accumulator:
  - ACC_W = DATA_W+COEF_W+clog2(TAPS), sign-extended sum.
  - If OUT_SHIFT>0, add 1<<(OUT_SHIFT-1) and then arithmetic-shift right by OUT_SHIFT (round half up). Otherwise pass through.
  - Limit to OUT_W per the optional feature.
- Coefficient write:
  - coef_we writes coef[coef_addr] at the clock edge. coef_addr>=TAPS is ignored.
  - If a write coincides with an acceptance, that sample's products use the pre-write coefficient. The write is visible from the next accepted sample.
  - Writes are honoured during stall.
- Simultaneous out handshake and new S1 result: S2 loads the new result and out_valid stays 1.

Optional Feature:
- Macro FIR_FILTER_SAT_EN.
- Defined: the scaled accumulator saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: it is truncated to the low OUT_W bits (two's-complement wrap).
- No port changes either way.

Decomposition:
- Shared package fir_pkg holds:
  - clog2 function;
  - ACC_W derivation;
  - default coefficient value constant (+1);
  - signed sample/coef typedefs parametrised via localparams.
- One natural sub-module, fir_round_sat: combinational round, shift and saturate/wrap stage. It is reused by later decimating variants.

Test Plan:
All scenarios use default parameters.
1. Reset, out_ready=1, feed impulse 1 then zeros -> out_data 1,1,1,1,1,0. First out_valid exactly 2 cycles after acceptance.
2. Write coefs 1,2,4,2,1 to taps 0..4, then step input 10 continuously -> out_data 10,30,70,90,100,100,...
3. Default coefs, input 100 continuously:
   - with FIR_FILTER_SAT_EN -> 100,127,127,127,127;
   - without -> 100,-56,44,-112,-12.
4. in_valid held 1, out_ready=0 for 5 cycles mid-stream -> in_ready=0 after the pipeline fills and out_data stays stable. After release, the output sequence matches the unstalled reference sample-for-sample.
5. Assert rst low asynchronously (mid-clock) with 2 samples in flight -> out_valid=0 and out_data=0 immediately, coefs return to 1. After release, impulse reproduces scenario 1.
6. coef_we with coef_addr=7 and data 50, then impulse -> outputs unchanged from scenario 1. A write coincident with acceptance affects only the next sample.
